// File: rtl/wb_bram_burst.sv
// -----------------------------------------------------------------------------
// wb_bram_burst
//   Wishbone B4 slave block RAM with registered-feedback burst support.
//   Serves classic single-word cycles and incrementing or wrapping bursts at
//   one beat per clock. Writes are byte-lane masked by sel. Out-of-range
//   requests get err instead of ack, with the same timing, and never write.
//
// Handshake: a beat completes on a rising edge where ack (or err) is high.
//   ack/err are only raised while the master holds cyc&stb (SINGLE relies on
//   the master holding the request until it is acknowledged). The master may
//   drop stb inside a burst to insert wait states. It ends a burst with
//   cti=111 on the last beat, or by dropping cyc, which abandons the burst
//   without a final ack.
//
// Ports
//   clk          in   1            system clock, rising edge
//   rst_n        in   1            asynchronous reset, active low
//   cyc          in   1            bus cycle valid
//   stb          in   1            strobe, beat request
//   we           in   1            1 = write, 0 = read
//   adr          in   32           byte address
//   sel          in   DATA_WIDTH/8 byte-lane write enables
//   dat_ms       in   DATA_WIDTH   write data, master to slave
//   cti          in   3            cycle type (000 classic, 010 incr, 111 end)
//   bte          in   2            burst type (00 linear, 01/10/11 wrap4/8/16)
//   dat_sm       out  DATA_WIDTH   read data, valid with ack when we=0
//   ack          out  1            beat acknowledge
//   err          out  1            error acknowledge, in place of ack
//   dbg_state_o  out  2            FSM state (0 idle, 1 single, 2 burst)
// -----------------------------------------------------------------------------
module wb_bram_burst #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [31:0]             adr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   dat_ms,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic [DATA_WIDTH-1:0]   dat_sm,
  output logic                    ack,
  output logic                    err,
  output logic [1:0]              dbg_state_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int BO        = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 0;
  localparam int HI        = ADDR_WIDTH + BO;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  // Any set bit at or above HI addresses beyond the array.
  localparam logic [31:0] HI_MASK = ~((32'd1 << HI) - 32'd1);

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_END  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SINGLE = 2'd1,
    S_BURST  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_adr_q, cur_adr_d;
  logic                    oor_q, oor_d;

  logic [ADDR_WIDTH-1:0]   adr_idx;
  logic                    adr_oor;
  logic [ADDR_WIDTH-1:0]   wrap_mask;
  logic [ADDR_WIDTH-1:0]   adr_inc;
  logic [ADDR_WIDTH-1:0]   next_adr;
  logic [ADDR_WIDTH-1:0]   rd_adr;

  logic                    ack_c;
  logic                    err_c;
  logic                    wr_en;

  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0]   rd_data_q;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign adr_idx = adr[HI-1:BO];
  assign adr_oor = |(adr & HI_MASK);

  // Burst address sequencing. A wrapping burst only advances the low
  // log2(N) bits of the word address; the bits above stay fixed so the
  // sequence stays inside its aligned N-word block.
  always_comb begin
    wrap_mask = '0;
    case (bte)
      2'b01:   wrap_mask = ADDR_WIDTH'(3);
      2'b10:   wrap_mask = ADDR_WIDTH'(7);
      2'b11:   wrap_mask = ADDR_WIDTH'(15);
      default: wrap_mask = '0;
    endcase
  end

  assign adr_inc = cur_adr_q + ADDR_WIDTH'(1);

  always_comb begin
    next_adr = adr_inc;
    if (wrap_mask != '0) begin
      next_adr = (cur_adr_q & ~wrap_mask) | (adr_inc & wrap_mask);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_adr_q <= '0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_adr_q <= cur_adr_d;
      oor_q     <= oor_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, beat outputs, write enable and read address
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cur_adr_d = cur_adr_q;
    oor_d     = oor_q;
    ack_c     = 1'b0;
    err_c     = 1'b0;
    wr_en     = 1'b0;
    rd_adr    = cur_adr_q;

    case (state_q)
      S_IDLE: begin
        // Reading straight from the bus address lets the first beat's data
        // be in the output register by the time its ack is raised.
        rd_adr = adr_idx;
        if (cyc && stb) begin
          cur_adr_d = adr_idx;
          oor_d     = adr_oor;
          // Reserved cycle types fall through to a classic single access.
          state_d   = (cti == CTI_INCR) ? S_BURST : S_SINGLE;
        end
      end

      S_SINGLE: begin
        // One-cycle acknowledge, then back to IDLE so two classic cycles
        // are never acked back to back.
        ack_c   = !oor_q;
        err_c   = oor_q;
        wr_en   = we && !oor_q;
        state_d = S_IDLE;
      end

      S_BURST: begin
        if (!cyc) begin
          state_d = S_IDLE;
        end else if (stb) begin
          // Acknowledge is combinational on stb so beats stream with no
          // bubbles. Each beat's range check uses the address the master
          // is presenting with that beat.
          ack_c     = !adr_oor;
          err_c     = adr_oor;
          wr_en     = we && !adr_oor;
          cur_adr_d = next_adr;
          // Pre-fetch the following beat so its data is registered by the
          // next edge; during wait states cur_adr already points there.
          rd_adr    = next_adr;
          if (cti == CTI_END) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory array: byte-lane masked writes. wr_en is derived from state_q,
  // which is forced to IDLE while reset is held, so a beat interrupted by
  // reset is never written.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (sel[i]) begin
          mem[cur_adr_q][8*i +: 8] <= dat_ms[8*i +: 8];
        end
      end
    end
  end

  // Synchronous read port with a resettable output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_adr];
    end
  end

  assign dat_sm      = rd_data_q;
  assign ack         = ack_c;
  assign err         = err_c;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_bram_burst.sv
// -----------------------------------------------------------------------------
// tb_wb_bram_burst
//   Directed and randomized checks of wb_bram_burst against a word-array
//   memory model. Burst address sequences are computed arithmetically from
//   the start word, the burst type and the beat number.
// -----------------------------------------------------------------------------
module tb_wb_bram_burst;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          cyc    = 1'b0;
  logic          stb    = 1'b0;
  logic          we     = 1'b0;
  logic [31:0]   adr    = '0;
  logic [SW-1:0] sel    = '0;
  logic [DW-1:0] dat_ms = '0;
  logic [2:0]    cti    = '0;
  logic [1:0]    bte    = '0;
  logic [DW-1:0] dat_sm;
  logic          ack;
  logic          err;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  wb_bram_burst #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cyc         (cyc),
    .stb         (stb),
    .we          (we),
    .adr         (adr),
    .sel         (sel),
    .dat_ms      (dat_ms),
    .cti         (cti),
    .bte         (bte),
    .dat_sm      (dat_sm),
    .ack         (ack),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model [0:DEPTH-1];
  logic [31:0] bdata [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int w, input logic [31:0] data, input logic [SW-1:0] s);
    for (int i = 0; i < SW; i++) begin
      if (s[i]) model[w][8*i +: 8] = data[8*i +: 8];
    end
  endtask

  // Word touched by beat k of a burst starting at word 'start'.
  function automatic int beat_word(input int start, input logic [1:0] b, input int k);
    int n;
    n = (b == 2'b00) ? 0 : (2 << b);
    if (n == 0) return (start + k) % DEPTH;
    return (start - (start % n)) + ((start % n) + k) % n;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic single(input logic [31:0] a, input bit wr, input logic [31:0] data,
                        input logic [SW-1:0] s, input bit exp_err, input string tag);
    int w;
    w = int'((a >> 2) % DEPTH);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = wr; adr = a; sel = s; dat_ms = data;
    cti = 3'b000; bte = 2'b00;
    @(negedge clk);
    chk({tag, "_noack_idle"}, 32'(ack), 32'd0);
    @(negedge clk);
    chk({tag, "_ack"}, 32'(ack), 32'(!exp_err));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    if (!wr && !exp_err) chk({tag, "_rdata"}, dat_sm, model[w]);
    @(posedge clk);
    if (wr && !exp_err) model_write(w, data, s);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_drop"}, 32'(ack), 32'd0);
    chk({tag, "_err_drop"}, 32'(err), 32'd0);
  endtask

  task automatic burst(input int start, input bit wr, input logic [1:0] b, input int n,
                       input int gap_after, input int gap_len, input bit rsel,
                       input string tag);
    int w;
    logic [SW-1:0] s;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = wr; bte = b; cti = 3'b010;
    adr = 32'(start * 4); sel = '1; dat_ms = bdata[0];
    @(negedge clk);
    chk({tag, "_noack_idle"}, 32'(ack), 32'd0);
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      #1;
      w = beat_word(start, b, k);
      stb = 1'b1;
      adr = 32'(w * 4);
      cti = (k == n - 1) ? 3'b111 : 3'b010;
      s = rsel ? SW'($urandom_range(0, (1 << SW) - 1)) : '1;
      sel = s;
      dat_ms = bdata[k];
      @(negedge clk);
      chk($sformatf("%s_ack_b%0d", tag, k), 32'(ack), 32'd1);
      chk($sformatf("%s_err_b%0d", tag, k), 32'(err), 32'd0);
      if (!wr) chk($sformatf("%s_rdata_b%0d", tag, k), dat_sm, model[w]);
      @(posedge clk);
      if (wr) model_write(w, bdata[k], s);
      if (k == gap_after && gap_len > 0) begin
        #1;
        stb = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          chk($sformatf("%s_gap%0d", tag, g), 32'(ack), 32'd0);
          @(posedge clk);
        end
      end
    end
    #1;
    cyc = 1'b0; stb = 1'b0; cti = 3'b000; we = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_end"}, 32'(ack), 32'd0);
    chk({tag, "_idle_end"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    int st, nb, ga, gl;
    logic [1:0] bb;
    logic [31:0] d;

    // Reset state.
    #2;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dat", dat_sm, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload the regions used below so every read has a known value.
    for (int w = 0; w < 64; w++) single(32'(w * 4), 1'b1, $urandom, '1, 1'b0, "pre");
    for (int w = DEPTH - 4; w < DEPTH; w++) single(32'(w * 4), 1'b1, $urandom, '1, 1'b0, "pre_top");

    // 1. Classic write and read back.
    single(32'h10, 1'b1, 32'hDEADBEEF, 4'b1111, 1'b0, "t1_wr");
    single(32'h10, 1'b0, 32'h0, 4'b0000, 1'b0, "t1_rd");
    chk("t1_const", model[4], 32'hDEADBEEF);

    // 2. Single-lane write merges into the existing word.
    single(32'h10, 1'b1, 32'h00AA0000, 4'b0100, 1'b0, "t2_wr");
    single(32'h10, 1'b0, 32'h0, 4'b0000, 1'b0, "t2_rd");

    // sel=0 write is acked but leaves memory alone.
    single(32'h14, 1'b1, 32'h12345678, 4'b0000, 1'b0, "sel0_wr");
    single(32'h14, 1'b0, 32'h0, 4'b0000, 1'b0, "sel0_rd");

    // 3. Linear 4-beat burst read of 1,2,3,4.
    for (int w = 0; w < 4; w++) single(32'(w * 4), 1'b1, 32'(w + 1), '1, 1'b0, "t3_pre");
    burst(0, 1'b0, 2'b00, 4, -1, 0, 1'b0, "t3_rd");

    // 4. Wrap4 burst write starting at word 2 lands on 2,3,0,1.
    bdata[0] = 32'hAAAA_AAAA; bdata[1] = 32'hBBBB_BBBB;
    bdata[2] = 32'hCCCC_CCCC; bdata[3] = 32'hDDDD_DDDD;
    burst(2, 1'b1, 2'b01, 4, -1, 0, 1'b0, "t4_wr");
    single(32'h08, 1'b0, 0, '0, 1'b0, "t4_rd2");
    single(32'h0C, 1'b0, 0, '0, 1'b0, "t4_rd3");
    single(32'h00, 1'b0, 0, '0, 1'b0, "t4_rd0");
    single(32'h04, 1'b0, 0, '0, 1'b0, "t4_rd1");
    chk("t4_w0", model[0], 32'hCCCC_CCCC);
    chk("t4_w2", model[2], 32'hAAAA_AAAA);

    // 5. Two wait states after the second beat.
    burst(0, 1'b0, 2'b00, 4, 1, 2, 1'b0, "t5_rd");

    // Linear burst across the top of the array wraps to word 0.
    burst(DEPTH - 2, 1'b0, 2'b00, 4, -1, 0, 1'b0, "top_wrap");

    // 6a. Reset asserted during beat 2 of a linear burst write from word 0.
    for (int k = 0; k < 3; k++) bdata[k] = $urandom;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; bte = 2'b00; cti = 3'b010;
    adr = 32'h0; sel = '1; dat_ms = bdata[0];
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      #1 adr = 32'(k * 4); dat_ms = bdata[k];
      @(negedge clk);
      chk("t6_ack_pre", 32'(ack), 32'd1);
      @(posedge clk);
      model_write(k, bdata[k], '1);
    end
    #1 adr = 32'h8; dat_ms = bdata[2];
    @(negedge clk);
    chk("t6_ack_b2", 32'(ack), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ack_rst", 32'(ack), 32'd0);
    chk("t6_err_rst", 32'(err), 32'd0);
    chk("t6_dat_rst", dat_sm, 32'd0);
    chk("t6_state_rst", 32'(dbg_state), 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    single(32'h00, 1'b0, 0, '0, 1'b0, "t6_rd0");
    single(32'h04, 1'b0, 0, '0, 1'b0, "t6_rd1");
    single(32'h08, 1'b0, 0, '0, 1'b0, "t6_rd2_unchanged");

    // 6b. Out-of-range accesses get err and never write.
    single(32'h0001_0000, 1'b1, 32'hFFFF_FFFF, '1, 1'b1, "oor_wr");
    single(32'h0000_0000, 1'b0, 0, '0, 1'b0, "oor_chk0");
    single(32'h8000_0004, 1'b0, 0, '0, 1'b1, "oor_rd");

    // Random classic cycles.
    for (int i = 0; i < 24; i++) begin
      st = $urandom_range(0, 63);
      d  = $urandom;
      if ($urandom_range(0, 1) == 1)
        single(32'(st * 4), 1'b1, d, SW'($urandom_range(0, (1 << SW) - 1)), 1'b0, "rnd_wr");
      else
        single(32'(st * 4), 1'b0, 0, '0, 1'b0, "rnd_rd");
    end

    // Random bursts with random burst type, length, lanes and wait states.
    for (int i = 0; i < 16; i++) begin
      bb = 2'($urandom_range(0, 3));
      if (bb == 2'b00) begin
        st = $urandom_range(0, 55);
        nb = $urandom_range(2, 8);
      end else begin
        st = $urandom_range(0, 63);
        nb = $urandom_range(2, 2 << bb);
      end
      ga = $urandom_range(0, nb - 2);
      gl = $urandom_range(0, 2);
      for (int k = 0; k < 16; k++) bdata[k] = $urandom;
      burst(st, ($urandom_range(0, 1) == 1), bb, nb, ga, gl, 1'b1, "rnd_burst");
    end

    // Final read-back sweep of the randomly exercised region.
    for (int w = 0; w < 64; w += 4) single(32'(w * 4), 1'b0, 0, '0, 1'b0, "sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
